// File: rtl/led_fader.sv
// Five-channel LED fader: each request snaps an LED to full brightness, then the level
// decays in fixed steps while a shared PWM counter drives the outputs. Optional macro: LED_FADER_GAMMA_EN.
module led_fader #(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 240000,
    parameter int DECAY_STEP = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] pattern_in,
    output logic [4:0] led_out,
    output logic       fade_active
);

    localparam int NUM_LEDS = 5;
    localparam int DIV_W    = $clog2(DECAY_DIV);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [DIV_W-1:0]    decay_cnt_reg;
    logic                decay_tick;

    logic [PWM_BITS-1:0] level_reg  [NUM_LEDS];
    logic [PWM_BITS-1:0] level_next [NUM_LEDS];
    logic [PWM_BITS-1:0] cmp        [NUM_LEDS];
    logic [NUM_LEDS-1:0] level_nz;
    logic [NUM_LEDS-1:0] led_next;

    logic [NUM_LEDS-1:0] led_out_reg;
    logic                fade_active_reg;

    assign decay_tick = (decay_cnt_reg == DIV_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_cnt_reg   <= '0;
            decay_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
            decay_cnt_reg <= decay_tick ? '0 : decay_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            // A request outranks a coincident tick; decrement saturates at zero.
            assign level_next[gi] = pattern_in[gi] ? LEVEL_MAX :
                                    !decay_tick    ? level_reg[gi] :
                                    (level_reg[gi] < STEP) ? '0 : level_reg[gi] - STEP;

`ifdef LED_FADER_GAMMA_EN
            logic [2*PWM_BITS-1:0] level_ext;
            assign level_ext = {{PWM_BITS{1'b0}}, level_reg[gi]};
            assign cmp[gi]   = PWM_BITS'((level_ext * level_ext) >> PWM_BITS);
`else
            assign cmp[gi]   = level_reg[gi];
`endif

            // Full level forces constant-on so there is no one-count dark gap at MAX.
            assign led_next[gi] = (level_reg[gi] == LEVEL_MAX) || (pwm_cnt_reg < cmp[gi]);
            assign level_nz[gi] = (level_reg[gi] != '0);
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_reg[i] <= '0;
            end
            led_out_reg     <= '0;
            fade_active_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level_reg[i] <= level_next[i];
            end
            led_out_reg     <= led_next;
            fade_active_reg <= |level_nz;
        end
    end

    assign led_out     = led_out_reg;
    assign fade_active = fade_active_reg;

endmodule

// File: tb/tb_led_fader.sv
// Randomized and directed bench for led_fader against a cycle-level brightness model
// (PWM_BITS=8, DECAY_DIV=4, DECAY_STEP=64).
module tb_led_fader;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [4:0] pattern_in = 5'b0;
    logic [4:0] led_out;
    logic       fade_active;

    int errors = 0;
    int checks = 0;

    // Reference state: brightness per LED, expected registered outputs, cycles since reset.
    int m_level [5];
    int m_led;
    int m_fade;
    int t;

    always #5 CLK = ~CLK;

    led_fader #(
        .PWM_BITS   (8),
        .DECAY_DIV  (4),
        .DECAY_STEP (64)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .pattern_in  (pattern_in),
        .led_out     (led_out),
        .fade_active (fade_active)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic int model_cmp(input int lvl);
`ifdef LED_FADER_GAMMA_EN
        return (lvl * lvl) / 256;
`else
        return lvl;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_level[i] = 0;
        m_led  = 0;
        m_fade = 0;
        t      = 0;
    endtask

    // Apply one request vector across one rising edge, advance the model, compare outputs.
    task automatic step(input logic [4:0] p);
        int  nl [5];
        int  nled;
        int  nf;
        bit  tick;
        pattern_in = p;
        @(posedge CLK);
        tick = ((t % 4) == 3);
        nled = 0;
        nf   = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_level[i] == 255 || (t % 256) < model_cmp(m_level[i])) nled |= (1 << i);
            if (m_level[i] != 0) nf = 1;
            if (p[i])      nl[i] = 255;
            else if (tick) nl[i] = (m_level[i] < 64) ? 0 : m_level[i] - 64;
            else           nl[i] = m_level[i];
        end
        for (int i = 0; i < 5; i++) m_level[i] = nl[i];
        m_led  = nled;
        m_fade = nf;
        t++;
        #1;
        check("led_out", int'(led_out), m_led);
        check("fade_active", int'(fade_active), m_fade);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(5'b0);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        #1;
        check("async_led_out", int'(led_out), 0);
        check("async_fade_active", int'(fade_active), 0);
        for (int k = 0; k < 2; k++) begin
            pattern_in = 5'($urandom_range(1, 31));
            @(posedge CLK);
            #1;
            check("rst_led_out", int'(led_out), 0);
            check("rst_fade_active", int'(fade_active), 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        bit found;
        model_reset();

        // Reset held with requests present: outputs must stay dark.
        for (int k = 0; k < 3; k++) begin
            pattern_in = 5'($urandom_range(0, 31));
            @(posedge CLK);
            #1;
            check("reset_led_out", int'(led_out), 0);
            check("reset_fade_active", int'(fade_active), 0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        $display("txn reset: led_out=%b fade_active=%b", led_out, fade_active);

        // Single pulse on LED1 and its full fade.
        step(5'b00001);
        idle(24);
        $display("txn pulse_led1: led_out=%b fade_active=%b", led_out, fade_active);

        // Request on LED3 landing exactly on a tick while its level is 63.
        step(5'b00100);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_level[2] == 63 && (t % 4) == 3) found = 1'b1;
            else step(5'b0);
        end
        if (!found) check("tick_load_timeout", 0, 1);
        step(5'b00100);
        step(5'b0);
        check("tick_load_led3", int'(led_out[2]), 1);
        idle(24);
        $display("txn tick_collision: led_out=%b fade_active=%b", led_out, fade_active);

        // Walking one-hot comet.
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) step(5'(1 << k));
        end
        idle(24);
        $display("txn comet: led_out=%b fade_active=%b", led_out, fade_active);

        // Reset in the middle of a fade.
        step(5'b11111);
        step(5'b0);
        apply_reset();
        idle(8);
        $display("txn midrun_reset: led_out=%b fade_active=%b", led_out, fade_active);

        // Sparse random requests, long enough to sweep several PWM windows.
        for (int blk = 0; blk < 8; blk++) begin
            for (int c = 0; c < 250; c++) begin
                logic [4:0] p;
                p = '0;
                for (int i = 0; i < 5; i++) p[i] = ($urandom_range(0, 15) == 0);
                step(p);
            end
            $display("txn random_block %0d: led_out=%b fade_active=%b", blk, led_out, fade_active);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
